// File: rtl/excp_flush_ctrl_pkg.sv
// Shared constants for the exception/ERTN flush controller: Ecode/EsubCode values,
// bit positions within ws_excp_num, and the controller state encoding.
package excp_flush_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;
    localparam logic [5:0] ECODE_DBG = 6'h3F;

    localparam logic [8:0] ESUBCODE_NONE = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    localparam int EXCP_BIT_INT  = 0;
    localparam int EXCP_BIT_ADEF = 1;
    localparam int EXCP_BIT_INE  = 2;
    localparam int EXCP_BIT_IPE  = 3;
    localparam int EXCP_BIT_SYS  = 4;
    localparam int EXCP_BIT_BRK  = 5;
    localparam int EXCP_BIT_ALE  = 6;
    localparam int EXCP_BIT_ADEM = 7;
    localparam int EXCP_BIT_RSVD = 8;

    localparam logic [1:0] EFC_IDLE     = 2'd0;
    localparam logic [1:0] EFC_FLUSH    = 2'd1;
    localparam logic [1:0] EFC_REDIRECT = 2'd2;

endpackage

// File: rtl/excp_ecode_enc.sv
// Priority encoder turning the WB exception vector into Ecode/EsubCode and a
// flag telling whether the cause records a bad virtual address.
module excp_ecode_enc
    import excp_flush_ctrl_pkg::*;
(
    input  logic [8:0] excp_num,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output logic       uses_badv
);

    // Highest-priority cause first; an empty or reserved-only vector yields the debug marker.
    always_comb begin
        ecode     = ECODE_DBG;
        esubcode  = ESUBCODE_NONE;
        uses_badv = 1'b0;
        if (excp_num[EXCP_BIT_INT]) begin
            ecode = ECODE_INT;
        end else if (excp_num[EXCP_BIT_ADEF]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUBCODE_ADEF;
            uses_badv = 1'b1;
        end else if (excp_num[EXCP_BIT_INE]) begin
            ecode = ECODE_INE;
        end else if (excp_num[EXCP_BIT_IPE]) begin
            ecode = ECODE_IPE;
        end else if (excp_num[EXCP_BIT_SYS]) begin
            ecode = ECODE_SYS;
        end else if (excp_num[EXCP_BIT_BRK]) begin
            ecode = ECODE_BRK;
        end else if (excp_num[EXCP_BIT_ALE]) begin
            ecode     = ECODE_ALE;
            uses_badv = 1'b1;
        end else if (excp_num[EXCP_BIT_ADEM]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUBCODE_ADEM;
            uses_badv = 1'b1;
        end else if (excp_num[EXCP_BIT_RSVD]) begin
            ecode = ECODE_DBG;
        end
    end

endmodule

// File: rtl/excp_flush_ctrl.sv
// Exception entry / ERTN return sequencer behind WB: CSR update pulse, timed pipeline
// flush, then an IF redirect held until accepted. EXCP_FLUSH_CTRL_INT_EN adds interrupt ports.
module excp_flush_ctrl
    import excp_flush_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            excp_flush,
    input  logic            ertn_flush,
    input  logic [8:0]      ws_excp_num,
    input  logic [PC_W-1:0] ws_pc,
    input  logic [PC_W-1:0] ws_badv,
    input  logic [PC_W-1:0] csr_eentry,
    input  logic [PC_W-1:0] csr_era,
`ifdef EXCP_FLUSH_CTRL_INT_EN
    input  logic            int_pending,
    input  logic            csr_crmd_ie,
`endif
    output logic            ctrl_busy,
    output logic            pipe_flush,
    output logic            csr_excp_we,
    output logic            csr_ertn_we,
    output logic            csr_badv_we,
    output logic [5:0]      csr_ecode,
    output logic [8:0]      csr_esubcode,
    output logic [PC_W-1:0] csr_era_wdata,
    output logic [PC_W-1:0] csr_badv_wdata,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             kind_excp;

    logic [5:0] enc_ecode;
    logic [8:0] enc_esubcode;
    logic       enc_uses_badv;

    logic       take_excp;
    logic [5:0] sel_ecode;
    logic [8:0] sel_esubcode;
    logic       sel_uses_badv;

    excp_ecode_enc u_enc (
        .excp_num  (ws_excp_num),
        .ecode     (enc_ecode),
        .esubcode  (enc_esubcode),
        .uses_badv (enc_uses_badv)
    );

`ifdef EXCP_FLUSH_CTRL_INT_EN
    // An enabled pending interrupt hijacks whatever instruction is committing.
    logic int_force;
    assign int_force     = int_pending & csr_crmd_ie & (excp_flush | ertn_flush);
    assign take_excp     = excp_flush | int_force;
    assign sel_ecode     = int_force ? ECODE_INT : enc_ecode;
    assign sel_esubcode  = int_force ? ESUBCODE_NONE : enc_esubcode;
    assign sel_uses_badv = int_force ? 1'b0 : enc_uses_badv;
`else
    assign take_excp     = excp_flush;
    assign sel_ecode     = enc_ecode;
    assign sel_esubcode  = enc_esubcode;
    assign sel_uses_badv = enc_uses_badv;
`endif

    assign ctrl_busy      = (state != EFC_IDLE);
    assign pipe_flush     = (state == EFC_FLUSH);
    assign redirect_valid = (state == EFC_REDIRECT);

    // CSR pulses are set on the IDLE->FLUSH edge so they land on the first FLUSH cycle only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= EFC_IDLE;
            cnt            <= '0;
            kind_excp      <= 1'b0;
            csr_excp_we    <= 1'b0;
            csr_ertn_we    <= 1'b0;
            csr_badv_we    <= 1'b0;
            csr_ecode      <= '0;
            csr_esubcode   <= '0;
            csr_era_wdata  <= '0;
            csr_badv_wdata <= '0;
            redirect_pc    <= '0;
        end else begin
            csr_excp_we <= 1'b0;
            csr_ertn_we <= 1'b0;
            csr_badv_we <= 1'b0;
            case (state)
                EFC_IDLE: begin
                    if (take_excp) begin
                        state          <= EFC_FLUSH;
                        cnt            <= '0;
                        kind_excp      <= 1'b1;
                        csr_excp_we    <= 1'b1;
                        csr_badv_we    <= sel_uses_badv;
                        csr_ecode      <= sel_ecode;
                        csr_esubcode   <= sel_esubcode;
                        csr_era_wdata  <= ws_pc;
                        csr_badv_wdata <= ws_badv;
                    end else if (ertn_flush) begin
                        state       <= EFC_FLUSH;
                        cnt         <= '0;
                        kind_excp   <= 1'b0;
                        csr_ertn_we <= 1'b1;
                    end
                end
                EFC_FLUSH: begin
                    if (cnt == CNT_LAST) begin
                        redirect_pc <= kind_excp ? csr_eentry : csr_era;
                        state       <= EFC_REDIRECT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EFC_REDIRECT: begin
                    if (redirect_ready) begin
                        state <= EFC_IDLE;
                    end
                end
                default: state <= EFC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Directed self-checking bench for excp_flush_ctrl (default build, FLUSH_CYCLES=2).
module tb_excp_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush;
    logic        ertn_flush;
    logic [8:0]  ws_excp_num;
    logic [31:0] ws_pc;
    logic [31:0] ws_badv;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
`ifdef EXCP_FLUSH_CTRL_INT_EN
    logic        int_pending;
    logic        csr_crmd_ie;
`endif
    logic        ctrl_busy;
    logic        pipe_flush;
    logic        csr_excp_we;
    logic        csr_ertn_we;
    logic        csr_badv_we;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_era_wdata;
    logic [31:0] csr_badv_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    excp_flush_ctrl #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .excp_flush     (excp_flush),
        .ertn_flush     (ertn_flush),
        .ws_excp_num    (ws_excp_num),
        .ws_pc          (ws_pc),
        .ws_badv        (ws_badv),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
`ifdef EXCP_FLUSH_CTRL_INT_EN
        .int_pending    (int_pending),
        .csr_crmd_ie    (csr_crmd_ie),
`endif
        .ctrl_busy      (ctrl_busy),
        .pipe_flush     (pipe_flush),
        .csr_excp_we    (csr_excp_we),
        .csr_ertn_we    (csr_ertn_we),
        .csr_badv_we    (csr_badv_we),
        .csr_ecode      (csr_ecode),
        .csr_esubcode   (csr_esubcode),
        .csr_era_wdata  (csr_era_wdata),
        .csr_badv_wdata (csr_badv_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic excp, input logic ertn, input logic [8:0] num,
                                 input logic [31:0] pc, input logic [31:0] badv);
        excp_flush  = excp;
        ertn_flush  = ertn;
        ws_excp_num = num;
        ws_pc       = pc;
        ws_badv     = badv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        redirect_ready = 1'b0;
        csr_eentry = 32'h1C008000;
        csr_era    = 32'h1C000014;
`ifdef EXCP_FLUSH_CTRL_INT_EN
        int_pending = 1'b0;
        csr_crmd_ie = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("rst_busy", 32'(ctrl_busy), 32'd0);
        checkOutput("rst_flush", 32'(pipe_flush), 32'd0);
        checkOutput("rst_rvalid", 32'(redirect_valid), 32'd0);
        checkOutput("rst_excp_we", 32'(csr_excp_we), 32'd0);
        checkOutput("rst_ecode", 32'(csr_ecode), 32'd0);
        reset = 1'b0;
        tick();

        // SYS exception; excp_flush left high in FLUSH must be ignored
        applyStimulus(1'b1, 1'b0, 9'h010, 32'h1C000010, 32'h0);
        tick();
        checkOutput("sys_excp_we", 32'(csr_excp_we), 32'd1);
        checkOutput("sys_ecode", 32'(csr_ecode), 32'h0B);
        checkOutput("sys_era", csr_era_wdata, 32'h1C000010);
        checkOutput("sys_badv_we", 32'(csr_badv_we), 32'd0);
        checkOutput("sys_ertn_we", 32'(csr_ertn_we), 32'd0);
        checkOutput("sys_flush1", 32'(pipe_flush), 32'd1);
        checkOutput("sys_busy", 32'(ctrl_busy), 32'd1);
        tick();
        checkOutput("sys_pulse_once", 32'(csr_excp_we), 32'd0);
        checkOutput("sys_flush2", 32'(pipe_flush), 32'd1);
        checkOutput("sys_rvalid_early", 32'(redirect_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        tick();
        checkOutput("sys_rvalid", 32'(redirect_valid), 32'd1);
        checkOutput("sys_rpc", redirect_pc, 32'h1C008000);
        checkOutput("sys_flush_off", 32'(pipe_flush), 32'd0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        checkOutput("sys_idle", 32'(ctrl_busy), 32'd0);
        checkOutput("sys_rvalid_off", 32'(redirect_valid), 32'd0);

        // ERTN return
        applyStimulus(1'b0, 1'b1, 9'h000, 32'h1C000020, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        checkOutput("ertn_we", 32'(csr_ertn_we), 32'd1);
        checkOutput("ertn_no_excp", 32'(csr_excp_we), 32'd0);
        tick();
        checkOutput("ertn_pulse_once", 32'(csr_ertn_we), 32'd0);
        tick();
        checkOutput("ertn_rpc", redirect_pc, 32'h1C000014);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // ALE with BADV
        applyStimulus(1'b1, 1'b0, 9'h040, 32'h1C000030, 32'h00000003);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        checkOutput("ale_ecode", 32'(csr_ecode), 32'h09);
        checkOutput("ale_badv_we", 32'(csr_badv_we), 32'd1);
        checkOutput("ale_badv", csr_badv_wdata, 32'h3);
        tick();
        checkOutput("ale_badv_once", 32'(csr_badv_we), 32'd0);
        tick();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // excp+ertn together with ADEF|INE, then stalled redirect
        applyStimulus(1'b1, 1'b1, 9'h006, 32'h1C000040, 32'h1C000040);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        checkOutput("adef_ecode", 32'(csr_ecode), 32'h08);
        checkOutput("adef_sub", 32'(csr_esubcode), 32'd0);
        checkOutput("adef_excp_we", 32'(csr_excp_we), 32'd1);
        checkOutput("adef_no_ertn", 32'(csr_ertn_we), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rvalid", 32'(redirect_valid), 32'd1);
            checkOutput("stall_rpc", redirect_pc, 32'h1C008000);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        checkOutput("stall_idle", 32'(ctrl_busy), 32'd0);

        // ADEM carries EsubCode 1; empty vector gives the debug marker
        applyStimulus(1'b1, 1'b0, 9'h080, 32'h1C000050, 32'h00000100);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        checkOutput("adem_ecode", 32'(csr_ecode), 32'h08);
        checkOutput("adem_sub", 32'(csr_esubcode), 32'd1);
        tick();
        tick();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 9'h000, 32'h1C000060, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        checkOutput("dbg_ecode", 32'(csr_ecode), 32'h3F);
        checkOutput("dbg_badv_we", 32'(csr_badv_we), 32'd0);
        tick();
        tick();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // Reset during FLUSH, then a fresh SYS
        applyStimulus(1'b1, 1'b0, 9'h010, 32'h1C000070, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstf_busy", 32'(ctrl_busy), 32'd0);
        checkOutput("rstf_flush", 32'(pipe_flush), 32'd0);
        checkOutput("rstf_excp_we", 32'(csr_excp_we), 32'd0);
        checkOutput("rstf_ecode", 32'(csr_ecode), 32'd0);
        checkOutput("rstf_era", csr_era_wdata, 32'd0);
        checkOutput("rstf_rpc", redirect_pc, 32'd0);
        tick();
        checkOutput("rstf_no_pulse", 32'(csr_excp_we), 32'd0);
        applyStimulus(1'b1, 1'b0, 9'h010, 32'h1C000080, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 32'h0);
        checkOutput("post_excp_we", 32'(csr_excp_we), 32'd1);
        checkOutput("post_ecode", 32'(csr_ecode), 32'h0B);
        checkOutput("post_era", csr_era_wdata, 32'h1C000080);
        tick();
        tick();
        checkOutput("post_rpc", redirect_pc, 32'h1C008000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
